isr_dispatch: RTL and testbench

ISR_DISPATCH -- requirements
Module: isr_dispatch

---
 rtl/isr_pkg.sv | 26 ++
 rtl/isr_dispatch_if.sv | 44 ++++
 rtl/isr_fifo.sv | 64 ++++++
 rtl/isr_dispatch.sv | 123 ++++++++++++
 tb/tb_isr_dispatch.sv | 377 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/isr_pkg.sv
// -----------------------------------------------------------------------------
// isr_pkg
// Shared widths and the controller state encoding for the integer square-root
// dispatcher (isr_dispatch), its operand queue (isr_fifo) and its bus interface
// (isr_dispatch_if).
// -----------------------------------------------------------------------------
package isr_pkg;

  localparam int VALUE_W  = 64;  // operand width
  localparam int RESULT_W = 32;  // floor(sqrt(operand)) width
  localparam int COUNT_W  = 16;  // completed-result counter width

  // IDLE  : queue empty, nothing in flight
  // ISSUE : start pulse to the ISR unit
  // GUARD : one cycle in which isr_done is ignored (stale done mask)
  // WAIT  : waiting for isr_done
  // HOLD  : result presented downstream until accepted
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    GUARD = 3'd2,
    WAIT  = 3'd3,
    HOLD  = 3'd4
  } isr_state_t;

endpackage

// File: rtl/isr_dispatch_if.sv
// -----------------------------------------------------------------------------
// isr_dispatch_if
// Bundles the three handshakes of the dispatcher:
//   in_*   : operand input  (push = in_valid && in_ready at posedge)
//   isr_*  : ISR unit side  (isr_start pulse, isr_done completion flag)
//   out_*  : result output  (pop  = out_valid && out_ready at posedge)
//   done_count : results accepted downstream, modulo 2^16
// Handshake rule for in_* and out_*: a transfer happens at a rising clock edge
// exactly when valid and ready are both high; valid-side data must stay stable
// while valid is high and ready is low.
// Modports: slave = the dispatcher, master = the environment driving it.
// -----------------------------------------------------------------------------
interface isr_dispatch_if;
  import isr_pkg::*;

  logic                in_valid;
  logic [VALUE_W-1:0]  in_value;
  logic                in_ready;

  logic                isr_start;
  logic [VALUE_W-1:0]  isr_value;
  logic [RESULT_W-1:0] isr_result;
  logic                isr_done;

  logic                out_valid;
  logic [VALUE_W-1:0]  out_value;
  logic [RESULT_W-1:0] out_result;
  logic                out_ready;

  logic [COUNT_W-1:0]  done_count;

  modport slave (
    input  in_valid, in_value, isr_result, isr_done, out_ready,
    output in_ready, isr_start, isr_value, out_valid, out_value, out_result,
           done_count
  );

  modport master (
    output in_valid, in_value, isr_result, isr_done, out_ready,
    input  in_ready, isr_start, isr_value, out_valid, out_value, out_result,
           done_count
  );

endinterface

// File: rtl/isr_fifo.sv
// -----------------------------------------------------------------------------
// isr_fifo
// Operand queue of DEPTH 64-bit entries (DEPTH a power of two, >= 2).
// Ports:
//   clock, reset : clock, asynchronous active-high reset (empties the queue)
//   i_push/i_data: write request and data; ignored while full
//   i_pop        : read request; ignored while empty
//   o_data       : head entry (valid while !o_empty)
//   o_full/o_empty/o_count : occupancy status
// Push and pop in the same cycle both take effect. A push while full is
// dropped even if a pop happens in the same cycle.
// -----------------------------------------------------------------------------
module isr_fifo
  import isr_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     i_push,
  input  logic [VALUE_W-1:0]       i_data,
  input  logic                     i_pop,
  output logic [VALUE_W-1:0]       o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [VALUE_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]      r_wr_ptr;
  logic [AW-1:0]      r_rd_ptr;
  logic [AW:0]        r_count;
  logic               w_push;
  logic               w_pop;

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_data  = r_mem[r_rd_ptr];

  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop  && !o_empty;

  // Pointers are exactly AW bits wide, so they wrap modulo DEPTH for free.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/isr_dispatch.sv
// -----------------------------------------------------------------------------
// isr_dispatch
// Queues 64-bit operands and feeds them one at a time to an external integer
// square-root (ISR) unit, then presents {operand, result} downstream.
// Ports:
//   clock, reset : clock, asynchronous active-high reset
//   bus          : isr_dispatch_if.slave (operand input, ISR unit, result output,
//                  done_count)
//   o_dbg_state  : current controller state
//   o_dbg_count  : current queue occupancy
// Operands are issued strictly in arrival order. isr_done is ignored for one
// cycle after each start so a done flag left high by the previous operation is
// never mistaken for the new completion.
// -----------------------------------------------------------------------------
module isr_dispatch
  import isr_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  isr_dispatch_if.slave          bus,
  output isr_state_t             o_dbg_state,
  output logic [$clog2(DEPTH):0] o_dbg_count
);

  isr_state_t          r_state;
  isr_state_t          w_next;
  logic                w_pop;
  logic                w_latch;
  logic                w_accept;
  logic                w_full;
  logic                w_empty;
  logic [VALUE_W-1:0]  w_head;

  logic [VALUE_W-1:0]  r_isr_value;
  logic [VALUE_W-1:0]  r_out_value;
  logic [RESULT_W-1:0] r_out_result;
  logic [COUNT_W-1:0]  r_done_count;

  isr_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .i_push  (bus.in_valid),
    .i_data  (bus.in_value),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (o_dbg_count)
  );

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next-state and control strobes
  always_comb begin
    w_next   = r_state;
    w_pop    = 1'b0;
    w_latch  = 1'b0;
    w_accept = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop  = 1'b1;
          w_next = ISSUE;
        end
      end
      ISSUE: w_next = GUARD;
      GUARD: w_next = WAIT;
      WAIT: begin
        if (bus.isr_done) begin
          w_latch = 1'b1;
          w_next  = HOLD;
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          w_accept = 1'b1;
          if (!w_empty) begin
            w_pop  = 1'b1;
            w_next = ISSUE;
          end else begin
            w_next = IDLE;
          end
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Datapath registers: isr_value only changes on a pop, out_* only on a latch.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_isr_value  <= '0;
      r_out_value  <= '0;
      r_out_result <= '0;
      r_done_count <= '0;
    end else begin
      if (w_pop) r_isr_value <= w_head;
      if (w_latch) begin
        r_out_value  <= r_isr_value;
        r_out_result <= bus.isr_result;
      end
      if (w_accept) r_done_count <= r_done_count + 1'b1;
    end
  end

  // The queue's full flag alone gates input; no pass-through on a same-cycle pop.
  assign bus.in_ready   = !w_full;
  assign bus.isr_start  = (r_state == ISSUE);
  assign bus.isr_value  = r_isr_value;
  assign bus.out_valid  = (r_state == HOLD);
  assign bus.out_value  = r_out_value;
  assign bus.out_result = r_out_result;
  assign bus.done_count = r_done_count;

  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_isr_dispatch.sv
module tb_isr_dispatch;
  import isr_pkg::*;

  localparam int DEPTH = 4;

  // ---------------- clock / reset ----------------
  logic clock;
  logic reset;
  isr_state_t dbg_state;
  logic [$clog2(DEPTH):0] dbg_count;

  isr_dispatch_if bus_if();

  isr_dispatch #(.DEPTH(DEPTH)) dut (
    .clock       (clock),
    .reset       (reset),
    .bus         (bus_if.slave),
    .o_dbg_state (dbg_state),
    .o_dbg_count (dbg_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  logic [95:0] exp_q[$];
  logic [15:0] exp_done;

  // ---------------- reference sqrt ----------------
  function automatic logic [31:0] isqrt(input logic [63:0] v);
    logic [31:0] r;
    logic [31:0] t;
    r = '0;
    for (int b = 31; b >= 0; b--) begin
      t = r | (32'd1 << b);
      if (64'(t) * 64'(t) <= v) r = t;
    end
    return r;
  endfunction

  // ---------------- ISR unit model ----------------
  // sticky=0: done pulses one cycle. sticky=1: done stays high after a result
  // and only drops two negedges after the next start is seen.
  bit          sticky;
  int          lat_min;
  int          lat_max;
  logic [63:0] m_op;
  int          m_cnt;
  bit          m_busy;
  int          m_drop;

  always @(negedge clock) begin
    if (reset) begin
      m_busy = 0;
      m_drop = 0;
      bus_if.isr_done   = 1'b0;
      bus_if.isr_result = '0;
    end else if (bus_if.isr_start) begin
      m_op   = bus_if.isr_value;
      m_cnt  = $urandom_range(lat_max, lat_min);
      m_busy = 1;
      if (sticky) m_drop = 2;
      else begin
        m_drop = 0;
        bus_if.isr_done = 1'b0;
      end
    end else begin
      if (m_drop > 0) begin
        m_drop--;
        if (m_drop == 0) bus_if.isr_done = 1'b0;
      end else if (!sticky) begin
        bus_if.isr_done = 1'b0;
      end
      if (m_busy) begin
        if (m_cnt == 0) begin
          bus_if.isr_result = isqrt(m_op);
          bus_if.isr_done   = 1'b1;
          m_busy = 0;
        end else begin
          m_cnt--;
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  logic [95:0] sb_exp;
  always @(negedge clock) begin
    if (reset) begin
      exp_q.delete();
    end else begin
      if (bus_if.in_valid && bus_if.in_ready)
        exp_q.push_back({bus_if.in_value, isqrt(bus_if.in_value)});
      if (bus_if.out_valid && bus_if.out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: got value=%h result=%h, required no output",
                   bus_if.out_value, bus_if.out_result);
        end else begin
          sb_exp = exp_q.pop_front();
          if ({bus_if.out_value, bus_if.out_result} !== sb_exp) begin
            errors++;
            $display("FAIL sb_result: got value=%h result=%h, required value=%h result=%h",
                     bus_if.out_value, bus_if.out_result, sb_exp[95:32], sb_exp[31:0]);
          end
        end
        exp_done = exp_done + 16'd1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [63:0] v);
    int guard;
    guard = 0;
    while (!bus_if.in_ready && guard < 200) begin
      tick(1);
      guard++;
    end
    checks++;
    if (!bus_if.in_ready) begin
      errors++;
      $display("FAIL push_timeout: in_ready=%0b, required 1", bus_if.in_ready);
    end
    bus_if.in_valid = 1'b1;
    bus_if.in_value = v;
    tick(1);
    bus_if.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int guard;
    guard = 0;
    while ((exp_q.size() != 0 || dbg_state != IDLE) && guard < 1000) begin
      tick(1);
      guard++;
    end
    checks++;
    if (exp_q.size() != 0 || dbg_state != IDLE) begin
      errors++;
      $display("FAIL drain_timeout: pending=%0d state=%0d, required 0 and IDLE",
               exp_q.size(), dbg_state);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    tick(3);
    checks++;
    if (bus_if.in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready_during: got %0b required 1", bus_if.in_ready);
    end
    reset = 1'b0;
    tick(2);
    checks++;
    if (dbg_state !== IDLE || bus_if.isr_start !== 1'b0 || bus_if.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got state=%0d start=%0b out_valid=%0b, required 0 0 0",
               dbg_state, bus_if.isr_start, bus_if.out_valid);
    end
    checks++;
    if (bus_if.isr_value !== '0 || bus_if.out_value !== '0 || bus_if.out_result !== '0 ||
        bus_if.done_count !== '0 || bus_if.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_data: got isr_value=%h out_value=%h out_result=%h done=%h in_ready=%0b, required zeros and in_ready=1",
               bus_if.isr_value, bus_if.out_value, bus_if.out_result, bus_if.done_count, bus_if.in_ready);
    end
  endtask

  task automatic test_basic();
    int guard;
    bus_if.out_ready = 1'b0;
    push(64'd25);
    checks++;
    if (bus_if.isr_start !== 1'b0 || dbg_state !== IDLE) begin
      errors++; $display("FAIL basic_e0: got start=%0b state=%0d, required 0 IDLE",
                         bus_if.isr_start, dbg_state);
    end
    tick(1);
    checks++;
    if (bus_if.isr_start !== 1'b1 || bus_if.isr_value !== 64'd25) begin
      errors++; $display("FAIL basic_start_e1: got start=%0b isr_value=%h, required 1 25",
                         bus_if.isr_start, bus_if.isr_value);
    end
    tick(1);
    checks++;
    if (bus_if.isr_start !== 1'b0 || dbg_state !== GUARD) begin
      errors++; $display("FAIL basic_start_e2: got start=%0b state=%0d, required 0 GUARD",
                         bus_if.isr_start, dbg_state);
    end
    guard = 0;
    while (!bus_if.out_valid && guard < 100) begin tick(1); guard++; end
    checks++;
    if (bus_if.out_valid !== 1'b1 || bus_if.out_value !== 64'd25 || bus_if.out_result !== 32'd5) begin
      errors++; $display("FAIL basic_out: got valid=%0b value=%h result=%h, required 1 25 5",
                         bus_if.out_valid, bus_if.out_value, bus_if.out_result);
    end
    bus_if.out_ready = 1'b1;
    tick(1);
    bus_if.out_ready = 1'b0;
    tick(1);
    checks++;
    if (bus_if.done_count !== 16'd1 || bus_if.out_valid !== 1'b0) begin
      errors++; $display("FAIL basic_done: got done=%0d valid=%0b, required 1 0",
                         bus_if.done_count, bus_if.out_valid);
    end
  endtask

  task automatic test_extremes();
    bus_if.out_ready = 1'b1;
    push(64'hFFFF_FFFF_FFFF_FFE8);
    push(64'd0);
    push(64'd1);
    for (int i = 0; i < 4; i++) push({$urandom, $urandom});
    wait_drain();
    checks++;
    if (bus_if.done_count !== exp_done) begin
      errors++; $display("FAIL extremes_done: got %0d required %0d", bus_if.done_count, exp_done);
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] first;
    logic [63:0] v_hold;
    logic [31:0] r_hold;
    int guard;
    bus_if.out_ready = 1'b0;
    first = {$urandom, $urandom};
    push(first);
    for (int i = 0; i < 4; i++) push({$urandom, $urandom});
    guard = 0;
    while (dbg_state != HOLD && guard < 100) begin tick(1); guard++; end
    checks++;
    if (dbg_state !== HOLD || bus_if.in_ready !== 1'b0 || bus_if.out_value !== first) begin
      errors++; $display("FAIL bp_full: got state=%0d in_ready=%0b value=%h, required HOLD 0 %h",
                         dbg_state, bus_if.in_ready, bus_if.out_value, first);
    end
    v_hold = bus_if.out_value;
    r_hold = bus_if.out_result;
    bus_if.in_valid = 1'b1;
    bus_if.in_value = 64'hDEAD_BEEF_0000_0001;
    tick(5);
    bus_if.in_valid = 1'b0;
    checks++;
    if (bus_if.out_value !== v_hold || bus_if.out_result !== r_hold ||
        bus_if.out_valid !== 1'b1 || bus_if.in_ready !== 1'b0) begin
      errors++; $display("FAIL bp_stable: got value=%h result=%h valid=%0b in_ready=%0b, required %h %h 1 0",
                         bus_if.out_value, bus_if.out_result, bus_if.out_valid, bus_if.in_ready,
                         v_hold, r_hold);
    end
    bus_if.out_ready = 1'b1;
    wait_drain();
    checks++;
    if (bus_if.done_count !== exp_done) begin
      errors++; $display("FAIL bp_done: got %0d required %0d", bus_if.done_count, exp_done);
    end
  endtask

  task automatic test_sticky_done();
    sticky  = 1;
    lat_min = 2;
    lat_max = 5;
    bus_if.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) push({$urandom, $urandom});
    wait_drain();
    sticky  = 0;
    lat_min = 1;
    lat_max = 4;
    tick(2);
    checks++;
    if (bus_if.done_count !== exp_done) begin
      errors++; $display("FAIL sticky_done: got %0d required %0d", bus_if.done_count, exp_done);
    end
  endtask

  task automatic test_reset_mid();
    int guard;
    bit saw_valid;
    lat_min = 8;
    lat_max = 8;
    bus_if.out_ready = 1'b1;
    push(64'd1000);
    push(64'd2000);
    push(64'd3000);
    guard = 0;
    while (dbg_state != WAIT && guard < 50) begin tick(1); guard++; end
    checks++;
    if (dbg_state !== WAIT || dbg_count !== 2) begin
      errors++; $display("FAIL rmid_setup: got state=%0d count=%0d, required WAIT 2", dbg_state, dbg_count);
    end
    reset = 1'b1;
    #1;
    exp_done = 16'd0;
    checks++;
    if (dbg_state !== IDLE || bus_if.isr_start !== 1'b0 || bus_if.isr_value !== '0 ||
        bus_if.out_valid !== 1'b0 || bus_if.out_value !== '0 || bus_if.out_result !== '0 ||
        bus_if.done_count !== '0 || bus_if.in_ready !== 1'b1) begin
      errors++; $display("FAIL rmid_async: got state=%0d start=%0b isr_value=%h valid=%0b value=%h result=%h done=%h in_ready=%0b, required IDLE and zeros, in_ready=1",
                         dbg_state, bus_if.isr_start, bus_if.isr_value, bus_if.out_valid,
                         bus_if.out_value, bus_if.out_result, bus_if.done_count, bus_if.in_ready);
    end
    tick(2);
    reset = 1'b0;
    lat_min = 1;
    lat_max = 4;
    saw_valid = 0;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      if (bus_if.out_valid) saw_valid = 1;
    end
    checks++;
    if (saw_valid) begin
      errors++; $display("FAIL rmid_no_result: got out_valid=1 after reset, required 0");
    end
    push(64'd49);
    wait_drain();
    checks++;
    if (bus_if.out_result !== 32'd7 || bus_if.done_count !== 16'd1) begin
      errors++; $display("FAIL rmid_after: got result=%0d done=%0d, required 7 1",
                         bus_if.out_result, bus_if.done_count);
    end
  endtask

  task automatic test_wrap();
    force dut.r_done_count = 16'hFFFF;
    #1;
    release dut.r_done_count;
    exp_done = 16'hFFFF;
    tick(1);
    checks++;
    if (bus_if.done_count !== 16'hFFFF) begin
      errors++; $display("FAIL wrap_preload: got %h required FFFF", bus_if.done_count);
    end
    bus_if.out_ready = 1'b1;
    push(64'd144);
    wait_drain();
    checks++;
    if (bus_if.done_count !== 16'h0000 || bus_if.out_value !== 64'd144 ||
        bus_if.out_result !== 32'd12 || bus_if.in_ready !== 1'b1) begin
      errors++; $display("FAIL wrap: got done=%h value=%0d result=%0d in_ready=%0b, required 0000 144 12 1",
                         bus_if.done_count, bus_if.out_value, bus_if.out_result, bus_if.in_ready);
    end
  endtask

  // ---------------- sequence ----------------
  initial begin
    reset            = 1'b1;
    bus_if.in_valid  = 1'b0;
    bus_if.in_value  = '0;
    bus_if.out_ready = 1'b0;
    sticky           = 0;
    lat_min          = 1;
    lat_max          = 4;
    exp_done         = '0;

    test_reset();
    test_basic();
    test_extremes();
    test_backpressure();
    test_sticky_done();
    test_reset_mid();
    test_wrap();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
